ex_muldiv_ctrl: RTL and testbench
=================================

EX_MULDIV_CTRL -- requirements
Module: ex_muldiv_ctrl

Interface
REQ-001 Parameter NB, default 32, data width of operands, HI and LO.
REQ-002 Parameter NB_FCODE, default 6, width of the funct code.
REQ-003 Port i_clk, input, 1, single clock; all state changes on the rising edge.
REQ-004 Port i_reset, input, 1, reset; synchronous, active-high.
REQ-005 Port i_start, input, 1, EX stage holds an R-type instruction this cycle.
REQ-006 Port i_funct_code, input, NB_FCODE, funct of that instruction.
REQ-007 Port i_data_a, input, NB, rs operand: multiplicand or dividend.
REQ-008 Port i_data_b, input, NB, rt operand: multiplier or divisor.
REQ-009 Port i_flush, input, 1, abort any operation in flight.
REQ-010 Port o_stall, output, 1, freeze IF/ID/EX while the unit is occupied.
REQ-011 Port o_done, output, 1, one-cycle pulse when HI/LO update.
REQ-012 Port o_illegal, output, 1, one-cycle pulse for an unsupported muldiv funct.
REQ-013 Port o_hi, output, NB, HI register.
REQ-014 Port o_lo, output, NB, LO register.

Function
REQ-015 Accepted functs SHALL be MULT 0x18, MULTU 0x19, DIV 0x1A and DIVU 0x1B; any other funct SHALL be ignored without a stall.
REQ-016 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-017 In IDLE, i_start with an accepted funct SHALL latch the operands, the funct and the operand signs, clear the 5-bit iteration counter and enter BUSY.
REQ-018 BUSY SHALL run one shift-add (multiply) or restoring shift-subtract (divide) step per cycle for exactly 32 cycles; when the counter reaches 31 the FSM SHALL enter DONE.
REQ-019 The signed ops (MULT, DIV) SHALL operate on magnitudes and apply the result sign in the transition to DONE.
REQ-019a Signed divide: quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
REQ-020 On entry to DONE, MULT/MULTU SHALL write HI = product[2NB-1:NB] and LO = product[NB-1:0].
REQ-020a On entry to DONE, DIV/DIVU SHALL write HI = remainder and LO = quotient.
REQ-021 Division by zero SHALL complete with the same latency and write HI = i_data_a as latched and LO = all ones.
REQ-022 DONE SHALL last one cycle with o_done=1, then return to IDLE.
REQ-023 Total latency from the accepting edge to o_done SHALL be 33 cycles.
REQ-024 o_stall SHALL be combinational: 1 in IDLE when an accepted i_start is present, 1 throughout BUSY, 0 in DONE, 0 otherwise.
REQ-025 i_start in BUSY or DONE SHALL be ignored, because the pipeline is frozen.
REQ-026 A new accepted i_start in the DONE cycle SHALL be ignored; it is accepted on the following IDLE cycle.
REQ-027 i_flush SHALL take priority over i_start and over iteration progress.
REQ-027a i_flush SHALL return the FSM to IDLE at the next edge, leave HI/LO unchanged and suppress o_done.
REQ-028 Signed overflow, 0x80000000 / 0xFFFFFFFF with DIV, SHALL give LO = 0x80000000 and HI = 0.

Reset
REQ-029 i_reset SHALL have priority over every other input, including i_flush.
REQ-029a At the next edge after i_reset: FSM = IDLE, counter = 0, HI = LO = 0, internal operand and accumulator registers = 0.
REQ-029b During reset: o_done = o_illegal = o_stall = 0.
REQ-030 Reset asserted mid-operation SHALL abandon the operation with no o_done pulse.

Configuration
REQ-031 Macro EX_MULDIV_DIV_EN defined: DIV and DIVU SHALL be supported as in REQ-015 to REQ-028.
REQ-032 Macro EX_MULDIV_DIV_EN undefined: the divider datapath SHALL be absent.
REQ-032a Without the macro, DIV/DIVU with i_start in IDLE SHALL produce one o_illegal pulse at the next edge, with no stall and no HI/LO change.
REQ-032b Without the macro, multiply behaviour SHALL be identical to the macro-defined case.

Verification
REQ-033 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> o_stall high 33 cycles, o_done at cycle 33, HI=0xFFFFFFFE, LO=0x00000001.
REQ-034 MULT a=0xFFFFFFFD (-3), b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21).
REQ-035 DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
REQ-035a DIVU a=100, b=0 -> LO=0xFFFFFFFF, HI=100.
REQ-036 i_flush at cycle 10 of a MULTU -> IDLE next cycle, o_stall 0, o_done never pulses, HI/LO keep their prior values.
REQ-037 i_reset at cycle 20 of a DIV -> HI=LO=0, o_done never pulses.
REQ-037a Build without EX_MULDIV_DIV_EN, issue DIVU -> single o_illegal pulse, o_stall stays 0.

Source files
------------

// File: rtl/ex_muldiv_ctrl.sv
// Iterative HI/LO multiply/divide unit: 33 cycles from accepting edge to o_done, o_stall freezes the pipe meanwhile.
// Define EX_MULDIV_DIV_EN to build the restoring divider; without it DIV/DIVU raise o_illegal.
module ex_muldiv_ctrl #(
   parameter int NB       = 32,
   parameter int NB_FCODE = 6
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_start,
   input  logic [NB_FCODE-1:0] i_funct_code,
   input  logic [NB-1:0]       i_data_a,
   input  logic [NB-1:0]       i_data_b,
   input  logic                i_flush,
   output logic                o_stall,
   output logic                o_done,
   output logic                o_illegal,
   output logic [NB-1:0]       o_hi,
   output logic [NB-1:0]       o_lo
);

   localparam int                  NB_CNT   = $clog2(NB);
   localparam logic [NB_CNT-1:0]   CNT_LAST = NB_CNT'(NB - 1);
   localparam logic [NB_FCODE-1:0] F_MULT   = NB_FCODE'('h18);
   localparam logic [NB_FCODE-1:0] F_MULTU  = NB_FCODE'('h19);
   localparam logic [NB_FCODE-1:0] F_DIV    = NB_FCODE'('h1A);
   localparam logic [NB_FCODE-1:0] F_DIVU   = NB_FCODE'('h1B);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state, next_state;
   logic [NB_CNT-1:0] cnt;
   logic [NB-1:0]     acc, mq, opnd;
   logic [NB-1:0]     hi_q, lo_q;
   logic              neg_a, neg_b;
   logic              illegal_q;
   logic              stall;

   logic              is_mul_fn, is_div_fn, is_signed_fn;
   logic              accept_fn, illegal_fn, accept;
   logic [NB-1:0]     mag_a, mag_b;
   logic [NB:0]       mul_sum;
   logic [NB-1:0]     mul_acc, mul_mq;
   logic [2*NB-1:0]   prod, prod_res;
   logic [NB-1:0]     step_acc, step_mq, res_hi, res_lo;

   assign is_mul_fn    = (i_funct_code == F_MULT) || (i_funct_code == F_MULTU);
   assign is_div_fn    = (i_funct_code == F_DIV)  || (i_funct_code == F_DIVU);
   assign is_signed_fn = (i_funct_code == F_MULT) || (i_funct_code == F_DIV);

`ifdef EX_MULDIV_DIV_EN
   logic          is_div;
   logic [NB-1:0] a_raw;
   logic [NB:0]   div_diff;
   logic          div_ok;
   logic [NB-1:0] div_acc, div_mq, quo_res, rem_res;

   assign accept_fn  = is_mul_fn | is_div_fn;
   assign illegal_fn = 1'b0;
`else
   assign accept_fn  = is_mul_fn;
   assign illegal_fn = is_div_fn;
`endif

   assign accept = (state == IDLE) & i_start & accept_fn & ~i_flush;
   assign mag_a  = (is_signed_fn & i_data_a[NB-1]) ? -i_data_a : i_data_a;
   assign mag_b  = (is_signed_fn & i_data_b[NB-1]) ? -i_data_b : i_data_b;

   // Shift-add multiply: {acc, mq} holds the growing product, mq starts as the multiplier.
   assign mul_sum  = {1'b0, acc} + (mq[0] ? {1'b0, opnd} : '0);
   assign mul_acc  = mul_sum[NB:1];
   assign mul_mq   = {mul_sum[0], mq[NB-1:1]};
   assign prod     = {mul_acc, mul_mq};
   assign prod_res = (neg_a ^ neg_b) ? -prod : prod;

`ifdef EX_MULDIV_DIV_EN
   // Restoring divide: acc is the partial remainder, mq shifts dividend out and quotient in.
   assign div_diff = {acc, mq[NB-1]} - {1'b0, opnd};
   assign div_ok   = ~div_diff[NB];
   assign div_acc  = div_ok ? div_diff[NB-1:0] : {acc[NB-2:0], mq[NB-1]};
   assign div_mq   = {mq[NB-2:0], div_ok};
   assign quo_res  = (neg_a ^ neg_b) ? -div_mq : div_mq;
   assign rem_res  = neg_a ? -div_acc : div_acc;

   always_comb begin
      step_acc = mul_acc;
      step_mq  = mul_mq;
      res_hi   = prod_res[2*NB-1:NB];
      res_lo   = prod_res[NB-1:0];
      if (is_div) begin
         step_acc = div_acc;
         step_mq  = div_mq;
         if (opnd == '0) begin
            res_hi = a_raw;
            res_lo = '1;
         end else begin
            res_hi = rem_res;
            res_lo = quo_res;
         end
      end
   end
`else
   assign step_acc = mul_acc;
   assign step_mq  = mul_mq;
   assign res_hi   = prod_res[2*NB-1:NB];
   assign res_lo   = prod_res[NB-1:0];
`endif

   always_comb begin
      next_state = state;
      stall      = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               next_state = BUSY;
               stall      = 1'b1;
            end
         end
         BUSY: begin
            stall = 1'b1;
            if (i_flush)
               next_state = IDLE;
            else if (cnt == CNT_LAST)
               next_state = DONE;
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         cnt       <= '0;
         acc       <= '0;
         mq        <= '0;
         opnd      <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         neg_a     <= 1'b0;
         neg_b     <= 1'b0;
         illegal_q <= 1'b0;
`ifdef EX_MULDIV_DIV_EN
         is_div    <= 1'b0;
         a_raw     <= '0;
`endif
      end else begin
         illegal_q <= (state == IDLE) & i_start & illegal_fn & ~i_flush;
         if (accept) begin
            cnt   <= '0;
            acc   <= '0;
            mq    <= mag_a;
            opnd  <= mag_b;
            neg_a <= is_signed_fn & i_data_a[NB-1];
            neg_b <= is_signed_fn & i_data_b[NB-1];
`ifdef EX_MULDIV_DIV_EN
            is_div <= is_div_fn;
            a_raw  <= i_data_a;
`endif
         end else if (state == BUSY && !i_flush) begin
            cnt <= cnt + 1'b1;
            acc <= step_acc;
            mq  <= step_mq;
            if (cnt == CNT_LAST) begin
               hi_q <= res_hi;
               lo_q <= res_lo;
            end
         end
      end
   end

   assign o_stall   = stall & ~i_reset;
   assign o_done    = (state == DONE) & ~i_reset;
   assign o_illegal = illegal_q & ~i_reset;
   assign o_hi      = hi_q;
   assign o_lo      = lo_q;

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Directed bench for ex_muldiv_ctrl; divider vectors run when EX_MULDIV_DIV_EN is defined, illegal-funct vectors otherwise.
module tb_ex_muldiv_ctrl;

   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;
   localparam logic [5:0] F_ADD   = 6'h20;

   // Cycle 0 is the accepting cycle: stall in cycles 0..32, done in cycle 33.
   localparam logic [39:0] ST_FULL = 40'h01_FFFF_FFFF;
   localparam logic [39:0] DN_FULL = 40'h02_0000_0000;

   logic        i_clk, i_reset, i_start, i_flush;
   logic [5:0]  i_funct_code;
   logic [31:0] i_data_a, i_data_b;
   logic        o_stall, o_done, o_illegal;
   logic [31:0] o_hi, o_lo;

   int n_checks = 0;
   int n_errors = 0;
   logic [39:0] st, dn, il;

   ex_muldiv_ctrl #(.NB(32), .NB_FCODE(6)) dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_start      (i_start),
      .i_funct_code (i_funct_code),
      .i_data_a     (i_data_a),
      .i_data_b     (i_data_b),
      .i_flush      (i_flush),
      .o_stall      (o_stall),
      .o_done       (o_done),
      .o_illegal    (o_illegal),
      .o_hi         (o_hi),
      .o_lo         (o_lo)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called just after a rising edge; records stall/done/illegal per cycle over 40 cycles.
   task automatic run_op(input logic [5:0] funct, input logic [31:0] a, input logic [31:0] b,
                         input int flush_at, input int reset_at, input bit hold,
                         output logic [39:0] st_h, output logic [39:0] dn_h, output logic [39:0] il_h);
      i_funct_code = funct;
      i_data_a     = a;
      i_data_b     = b;
      i_start      = 1'b1;
      st_h = '0;
      dn_h = '0;
      il_h = '0;
      for (int c = 0; c < 40; c++) begin
         i_flush = (c == flush_at);
         i_reset = (c == reset_at);
         @(negedge i_clk);
         st_h[c] = o_stall;
         dn_h[c] = o_done;
         il_h[c] = o_illegal;
         @(posedge i_clk);
         #1;
         if (!hold) i_start = 1'b0;
      end
      i_flush = 1'b0;
      i_reset = 1'b0;
      i_start = 1'b0;
   endtask

   task automatic check_run(input string tag, input logic [39:0] exp_st, input logic [39:0] exp_dn,
                            input logic [39:0] exp_il, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      check_eq({tag, "_stall"},   64'(st),   64'(exp_st));
      check_eq({tag, "_done"},    64'(dn),   64'(exp_dn));
      check_eq({tag, "_illegal"}, 64'(il),   64'(exp_il));
      check_eq({tag, "_hi"},      64'(o_hi), 64'(exp_hi));
      check_eq({tag, "_lo"},      64'(o_lo), 64'(exp_lo));
   endtask

   initial begin
      i_reset      = 1'b1;
      i_start      = 1'b1;
      i_flush      = 1'b0;
      i_funct_code = F_MULTU;
      i_data_a     = 32'hFFFF_FFFF;
      i_data_b     = 32'hFFFF_FFFF;
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      check_eq("rst_stall",   64'(o_stall),   64'd0);
      check_eq("rst_done",    64'(o_done),    64'd0);
      check_eq("rst_illegal", 64'(o_illegal), 64'd0);
      check_eq("rst_hi",      64'(o_hi),      64'd0);
      check_eq("rst_lo",      64'(o_lo),      64'd0);
      @(posedge i_clk);
      #1;
      i_reset = 1'b0;
      i_start = 1'b0;
      @(posedge i_clk);
      #1;

      run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, 1'b0, st, dn, il);
      check_run("multu_max", ST_FULL, DN_FULL, '0, 32'hFFFF_FFFE, 32'h0000_0001);

      run_op(F_MULT, 32'hFFFF_FFFD, 32'd7, -1, -1, 1'b0, st, dn, il);
      check_run("mult_neg3x7", ST_FULL, DN_FULL, '0, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

      run_op(F_MULT, 32'h8000_0000, 32'h8000_0000, -1, -1, 1'b0, st, dn, il);
      check_run("mult_minxmin", ST_FULL, DN_FULL, '0, 32'h4000_0000, 32'h0000_0000);

      run_op(F_MULT, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, 1'b0, st, dn, il);
      check_run("mult_minxm1", ST_FULL, DN_FULL, '0, 32'h0000_0000, 32'h8000_0000);

      run_op(F_MULTU, 32'h0001_2345, 32'h0001_0000, -1, -1, 1'b0, st, dn, il);
      check_run("multu_shift", ST_FULL, DN_FULL, '0, 32'h0000_0001, 32'h2345_0000);

      run_op(F_MULT, 32'd5, 32'hFFFF_FFFC, -1, -1, 1'b0, st, dn, il);
      check_run("mult_5xneg4", ST_FULL, DN_FULL, '0, 32'hFFFF_FFFF, 32'hFFFF_FFEC);

      run_op(F_ADD, 32'd3, 32'd4, -1, -1, 1'b0, st, dn, il);
      check_run("ignored_fn", '0, '0, '0, 32'hFFFF_FFFF, 32'hFFFF_FFEC);

      run_op(F_MULTU, 32'h0000_1234, 32'h0000_0010, 10, -1, 1'b0, st, dn, il);
      check_run("flush_c10", 40'h7FF, '0, '0, 32'hFFFF_FFFF, 32'hFFFF_FFEC);

      run_op(F_MULT, 32'd0, 32'hFFFF_FFFB, -1, -1, 1'b0, st, dn, il);
      check_run("mult_zero", ST_FULL, DN_FULL, '0, 32'h0000_0000, 32'h0000_0000);

      // Start held high: ignored in DONE, re-accepted in the following IDLE cycle.
      run_op(F_MULTU, 32'd3, 32'd5, -1, -1, 1'b1, st, dn, il);
      check_run("held_start", 40'hFD_FFFF_FFFF, DN_FULL, '0, 32'h0000_0000, 32'h0000_000F);
      i_flush = 1'b1;
      @(posedge i_clk);
      #1;
      i_flush = 1'b0;
      @(negedge i_clk);
      check_eq("held_flush_stall", 64'(o_stall), 64'd0);
      check_eq("held_flush_lo",    64'(o_lo),    64'h0000_000F);
      @(posedge i_clk);
      #1;

`ifdef EX_MULDIV_DIV_EN
      run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, -1, -1, 1'b0, st, dn, il);
      check_run("div_neg7by2", ST_FULL, DN_FULL, '0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

      run_op(F_DIVU, 32'd100, 32'd0, -1, -1, 1'b0, st, dn, il);
      check_run("divu_by0", ST_FULL, DN_FULL, '0, 32'd100, 32'hFFFF_FFFF);

      run_op(F_DIV, 32'hFFFF_FFFB, 32'd0, -1, -1, 1'b0, st, dn, il);
      check_run("div_neg_by0", ST_FULL, DN_FULL, '0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);

      run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, 1'b0, st, dn, il);
      check_run("div_ovf", ST_FULL, DN_FULL, '0, 32'h0000_0000, 32'h8000_0000);

      run_op(F_DIVU, 32'hFFFF_FFFF, 32'h0000_0010, -1, -1, 1'b0, st, dn, il);
      check_run("divu_max", ST_FULL, DN_FULL, '0, 32'h0000_000F, 32'h0FFF_FFFF);

      run_op(F_DIV, 32'd7, 32'hFFFF_FFFE, -1, -1, 1'b0, st, dn, il);
      check_run("div_7byneg2", ST_FULL, DN_FULL, '0, 32'h0000_0001, 32'hFFFF_FFFD);

      run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, -1, 20, 1'b0, st, dn, il);
      check_run("div_reset_c20", 40'hF_FFFF, '0, '0, 32'h0000_0000, 32'h0000_0000);
`else
      run_op(F_DIVU, 32'd100, 32'd0, -1, -1, 1'b0, st, dn, il);
      check_run("divu_illegal", '0, '0, 40'h2, 32'h0000_0000, 32'h0000_000F);

      run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, -1, -1, 1'b0, st, dn, il);
      check_run("div_illegal", '0, '0, 40'h2, 32'h0000_0000, 32'h0000_000F);

      run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 20, 1'b0, st, dn, il);
      check_run("mul_reset_c20", 40'hF_FFFF, '0, '0, 32'h0000_0000, 32'h0000_0000);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
